// File: rtl/sccb_pkg.sv
// Shared state encoding and table constants for the SCCB camera init sequencer.
package sccb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StFetch,
        StIssue,
        StWait,
        StGap,
        StDone,
        StErr
    } state_e;

    localparam logic [15:0] END_MARK    = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG   = 8'hFE;
    localparam int unsigned RETRY_LIMIT = 3;

    // Counter load for an N-clock wait; a zero-length wait still spends one clock.
    function automatic logic [31:0] wait_load(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/sccb_init_seq.sv
// Walks a register table after power-up and issues one SCCB write per entry.
// Define SCCB_INIT_RETRY_EN to re-issue a NACKed entry up to RETRY_LIMIT times.
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned NUM_ENTRIES  = 64,
    parameter int unsigned GAP_CYCLES   = 1000,
    parameter int unsigned PWRUP_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        DEVRST_N,
    input  logic        start,
    output logic [5:0]  tbl_idx,
    input  logic [15:0] tbl_data,
    output logic        sccb_req,
    output logic [7:0]  sccb_dev,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ack,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fetch2_q, fetch2_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  val_q, val_d;
    logic [1:0]  retry_q, retry_d;
    logic        nack_q, nack_d;
    logic        last_entry;

    assign last_entry = (32'(idx_q) == NUM_ENTRIES - 32'd1);

    always_ff @(posedge clk or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fetch2_q <= 1'b0;
            idx_q    <= '0;
            dev_q    <= '0;
            reg_q    <= '0;
            val_q    <= '0;
            retry_q  <= '0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fetch2_q <= fetch2_d;
            idx_q    <= idx_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            val_q    <= val_d;
            retry_q  <= retry_d;
            nack_q   <= nack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fetch2_d = fetch2_q;
        idx_d    = idx_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        val_d    = val_q;
        retry_d  = retry_q;
        nack_d   = nack_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StPwrup;
                    cnt_d    = wait_load(32'(PWRUP_CYCLES));
                    idx_d    = '0;
                    retry_d  = '0;
                    nack_d   = 1'b0;
                    fetch2_d = 1'b0;
                end
            end
            StPwrup: begin
                if (cnt_q > 32'd1) cnt_d = cnt_q - 32'd1;
                else               state_d = StFetch;
            end
            StFetch: begin
                // First cycle lets the synchronous table catch up with idx.
                fetch2_d = ~fetch2_q;
                if (fetch2_q) begin
                    if (tbl_data == END_MARK) begin
                        state_d = StDone;
                    end else if (tbl_data[15:8] == DELAY_REG) begin
                        state_d = StGap;
                        cnt_d   = wait_load({14'd0, tbl_data[7:0], 10'd0});
                        nack_d  = 1'b0;
                    end else begin
                        state_d = StIssue;
                        dev_d   = DEV_ADDR;
                        reg_d   = tbl_data[15:8];
                        val_d   = tbl_data[7:0];
                    end
                end
            end
            StIssue: begin
                if (sccb_ack || sccb_nack) begin
                    state_d = StWait;
                    nack_d  = sccb_nack;
                end
            end
            StWait: begin
                state_d = StGap;
                cnt_d   = wait_load(32'(GAP_CYCLES));
                if (nack_q) begin
`ifdef SCCB_INIT_RETRY_EN
                    if (32'(retry_q) < RETRY_LIMIT) retry_d = retry_q + 2'd1;
                    else                            state_d = StErr;
`else
                    state_d = StErr;
`endif
                end
            end
            StGap: begin
                if (cnt_q > 32'd1) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (nack_q) begin
                    state_d = StFetch;  // retry: same index, fresh fetch
                end else if (last_entry) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                    idx_d   = idx_q + 6'd1;
                    retry_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sccb_req = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state_q)
            StPwrup, StFetch, StWait, StGap: busy = 1'b1;
            StIssue: begin
                busy     = 1'b1;
                sccb_req = 1'b1;
            end
            StDone:  done  = 1'b1;
            StErr:   error = 1'b1;
            default: ;
        endcase
    end

    assign tbl_idx  = idx_q;
    assign sccb_dev = dev_q;
    assign sccb_reg = reg_q;
    assign sccb_val = val_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Randomised bench for sccb_init_seq: table walk, timing, NACK handling and reset.
module tb_sccb_init_seq;

    localparam int unsigned Gap = 8;
    localparam int unsigned Pwr = 20;
    localparam int unsigned Num = 64;
    localparam logic [7:0]  Dev = 8'h42;
`ifdef SCCB_INIT_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        DEVRST_N = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  tbl_idx;
    logic [15:0] tbl_data;
    logic        sccb_req;
    logic [7:0]  sccb_dev, sccb_reg, sccb_val;
    logic        sccb_ack, sccb_nack;
    logic        busy, done, error;

    logic [15:0] rom [Num];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    sccb_init_seq #(
        .DEV_ADDR    (Dev),
        .NUM_ENTRIES (Num),
        .GAP_CYCLES  (Gap),
        .PWRUP_CYCLES(Pwr)
    ) dut (
        .clk      (clk),
        .DEVRST_N (DEVRST_N),
        .start    (start),
        .tbl_idx  (tbl_idx),
        .tbl_data (tbl_data),
        .sccb_req (sccb_req),
        .sccb_dev (sccb_dev),
        .sccb_reg (sccb_reg),
        .sccb_val (sccb_val),
        .sccb_ack (sccb_ack),
        .sccb_nack(sccb_nack),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tbl_data <= rom[tbl_idx];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Responder plan: one (latency, nack) pair per request, in order.
    int plan_lat[$];
    bit plan_nack[$];
    int rsp_i = 0;

    function automatic int plan_lat_at(input int k);
        return (k < plan_lat.size()) ? plan_lat[k] : 1;
    endfunction

    function automatic bit plan_nack_at(input int k);
        return (k < plan_nack.size()) ? plan_nack[k] : 1'b0;
    endfunction

    task automatic add_rsp(input int lat, input bit nk);
        plan_lat.push_back(lat);
        plan_nack.push_back(nk);
    endtask

    int rsp_lat;
    bit rsp_nk;
    bit rsp_prev = 1'b0;
    initial begin
        sccb_ack  = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (sccb_req && !rsp_prev) begin
                rsp_lat = plan_lat_at(rsp_i);
                rsp_nk  = plan_nack_at(rsp_i);
                rsp_i++;
                repeat (rsp_lat) @(negedge clk);
                if (rsp_nk) sccb_nack = 1'b1;
                else        sccb_ack  = 1'b1;
                @(negedge clk);
                sccb_ack  = 1'b0;
                sccb_nack = 1'b0;
            end
            rsp_prev = sccb_req;
        end
    end

    // Bus monitor: request edges, fields at assertion, field stability.
    int         mon_rise[$];
    int         mon_fall[$];
    logic [7:0] mon_reg[$], mon_val[$], mon_dev[$];
    bit         mon_stable[$];
    bit         mon_prev = 1'b0;
    bit         mon_ok = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (sccb_req && !mon_prev) begin
                mon_rise.push_back(cyc);
                mon_reg.push_back(sccb_reg);
                mon_val.push_back(sccb_val);
                mon_dev.push_back(sccb_dev);
                mon_ok = 1'b1;
            end else if (sccb_req) begin
                if (sccb_reg !== mon_reg[$] || sccb_val !== mon_val[$] || sccb_dev !== mon_dev[$])
                    mon_ok = 1'b0;
            end else if (mon_prev) begin
                mon_fall.push_back(cyc);
                mon_stable.push_back(mon_ok);
            end
            mon_prev = sccb_req;
        end
    end

    // Reference model: expected writes, request spacing/length and final status.
    logic [7:0] exp_reg[$], exp_val[$];
    int         exp_space[$], exp_len[$];
    bit         exp_done, exp_err;
    int         exp_idx;

    task automatic build_model();
        logic [15:0] e;
        int idx, rt, k, base, extra;
        bit nk;
        exp_reg.delete(); exp_val.delete(); exp_space.delete(); exp_len.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        idx = 0; rt = 0; k = 0; base = Pwr; extra = 0;
        forever begin
            e = rom[idx];
            if (e == 16'hFFFF) begin
                exp_done = 1'b1;
                break;
            end
            if (e[15:8] == 8'hFE) begin
                extra += 2 + ((e[7:0] == 8'd0) ? 1 : int'(e[7:0]) * 1024);
            end else begin
                exp_reg.push_back(e[15:8]);
                exp_val.push_back(e[7:0]);
                exp_space.push_back(base + extra + 2);
                exp_len.push_back(plan_lat_at(k) + 1);
                nk = plan_nack_at(k);
                k++;
                base  = 1 + Gap;
                extra = 0;
                if (nk) begin
                    if (RetryEn && rt < 3) begin
                        rt++;
                        continue;
                    end
                    exp_err = 1'b1;
                    break;
                end
            end
            if (idx == Num - 1) begin
                exp_done = 1'b1;
                break;
            end
            idx++;
            rt = 0;
        end
        exp_idx = idx;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < Num; i++) rom[i] = 16'hFFFF;
        plan_lat.delete();
        plan_nack.delete();
    endtask

    task automatic run_seq(input string name, input bit mid_start);
        int t0, nw;
        bit to;
        mon_rise.delete(); mon_fall.delete(); mon_reg.delete(); mon_val.delete();
        mon_dev.delete(); mon_stable.delete();
        rsp_i = 0;
        build_model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t0 = cyc;
        check_eq({name, ":busy_start"}, 32'(busy), 32'd1);
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                to = 1'b0;
                break;
            end
            start = mid_start && (i == 30 || i == 200);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        check_eq({name, ":finished"}, 32'(to), 32'd0);
        check_eq({name, ":writes"}, 32'(mon_rise.size()), 32'(exp_reg.size()));
        nw = (mon_fall.size() < exp_reg.size()) ? mon_fall.size() : exp_reg.size();
        for (int i = 0; i < nw; i++) begin
            check_eq($sformatf("%s:reg%0d", name, i), 32'(mon_reg[i]), 32'(exp_reg[i]));
            check_eq($sformatf("%s:val%0d", name, i), 32'(mon_val[i]), 32'(exp_val[i]));
            check_eq($sformatf("%s:dev%0d", name, i), 32'(mon_dev[i]), 32'(Dev));
            check_eq($sformatf("%s:stable%0d", name, i), 32'(mon_stable[i]), 32'd1);
            check_eq($sformatf("%s:len%0d", name, i), 32'(mon_fall[i] - mon_rise[i]),
                     32'(exp_len[i]));
            check_eq($sformatf("%s:space%0d", name, i),
                     32'(mon_rise[i] - ((i == 0) ? t0 : mon_fall[i-1])), 32'(exp_space[i]));
        end
        check_eq({name, ":done"},  32'(done),  32'(exp_done));
        check_eq({name, ":error"}, 32'(error), 32'(exp_err));
        check_eq({name, ":busy"},  32'(busy),  32'd0);
        check_eq({name, ":idx"},   32'(tbl_idx), 32'(exp_idx));
    endtask

    int n_ent;
    bit found;
    initial begin
        clear_tbl();
        repeat (3) @(negedge clk);
        check_eq("rst:req",  32'(sccb_req), 32'd0);
        check_eq("rst:busy", 32'(busy), 32'd0);
        check_eq("rst:done", 32'(done), 32'd0);
        check_eq("rst:err",  32'(error), 32'd0);
        check_eq("rst:idx",  32'(tbl_idx), 32'd0);
        check_eq("rst:dev",  32'(sccb_dev), 32'd0);
        DEVRST_N = 1'b1;
        repeat (3) @(negedge clk);

        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        add_rsp(5, 0); add_rsp(5, 0);
        run_seq("basic", 1'b0);

        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        add_rsp(3, 0); add_rsp(4, 1); add_rsp(2, 0); add_rsp(2, 0);
        add_rsp(2, 0); add_rsp(2, 0);
        run_seq("nack2", 1'b0);

        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        add_rsp(2, 1); add_rsp(3, 1); add_rsp(4, 1); add_rsp(2, 0); add_rsp(3, 0);
        run_seq("retry3", 1'b0);

        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        for (int i = 0; i < 4; i++) add_rsp(2, 1);
        add_rsp(2, 0);
        run_seq("nack4", 1'b0);

        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'hFE02; rom[2] = 16'h1101;
        add_rsp(2, 0); add_rsp(2, 0);
        run_seq("delay", 1'b0);

        clear_tbl();
        for (int i = 0; i < Num; i++) begin
            rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            add_rsp($urandom_range(1, 6), 0);
        end
        run_seq("full64", 1'b1);

        for (int r = 0; r < 4; r++) begin
            clear_tbl();
            n_ent = $urandom_range(1, 6);
            for (int i = 0; i < n_ent; i++) begin
                if ($urandom_range(0, 9) == 0)
                    rom[i] = {8'hFE, 8'($urandom_range(0, 1))};
                else
                    rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            end
            for (int i = 0; i < 24; i++) add_rsp($urandom_range(1, 6), ($urandom_range(0, 4) == 0));
            run_seq($sformatf("rand%0d", r), 1'b0);
        end

        // Reset while the second write is on the bus.
        clear_tbl();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        add_rsp(3, 0); add_rsp(9, 0);
        rsp_i = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sccb_req && tbl_idx == 6'd1) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("arst:req_seen", 32'(found), 32'd1);
        #2 DEVRST_N = 1'b0;
        #1;
        check_eq("arst:req",  32'(sccb_req), 32'd0);
        check_eq("arst:busy", 32'(busy), 32'd0);
        check_eq("arst:done", 32'(done), 32'd0);
        check_eq("arst:err",  32'(error), 32'd0);
        check_eq("arst:idx",  32'(tbl_idx), 32'd0);
        check_eq("arst:dev",  32'(sccb_dev), 32'd0);
        check_eq("arst:reg",  32'(sccb_reg), 32'd0);
        check_eq("arst:val",  32'(sccb_val), 32'd0);
        @(negedge clk);
        DEVRST_N = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("arst:idle_busy", 32'(busy), 32'd0);
        check_eq("arst:idle_req",  32'(sccb_req), 32'd0);

        clear_tbl();
        rom[0] = 16'h3A5C; rom[1] = 16'h0077; rom[2] = 16'h5511;
        add_rsp(1, 0); add_rsp(6, 0); add_rsp(3, 0);
        run_seq("after_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
